// File: rtl/strive_rst_ctl.sv
// rtl/strive_rst_ctl.sv - core reset / clock-select sequencer with kickable watchdog
// A clock-source change is only ever applied while ext_reset is held high.
module strive_rst_ctl #(
  parameter int PRE_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int WDT_W         = 16,
  parameter int WDT_LIMIT     = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_reset,
  input  logic req_clk_sel,
  output logic ext_reset,
  output logic ext_clk_sel,
  output logic done,
  input  logic wdt_enable,
  input  logic wdt_kick,
  output logic wdt_fired
);

  localparam int CNT_MAX = (PRE_CYCLES > SETTLE_CYCLES) ? PRE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] PRE_LAST    = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [WDT_W-1:0] WDT_MAX     = WDT_W'(WDT_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_SWITCH,
    S_SETTLE,
    S_RELEASE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sel_q, sel_d;
  logic               ext_reset_q, ext_reset_d;
  logic               ext_clk_sel_q, ext_clk_sel_d;
  logic               done_q, done_d;
  logic [WDT_W-1:0]   wdt_cnt_q, wdt_cnt_d;
  logic               wdt_fired_q, wdt_fired_d;

  logic accept;
  logic need_seq;
  logic wdt_expire;

  assign req_ready   = (state_q == S_IDLE) & ~reset;
  assign ext_reset   = ext_reset_q;
  assign ext_clk_sel = ext_clk_sel_q;
  assign done        = done_q;
  assign wdt_fired   = wdt_fired_q;

  assign accept     = req_valid & req_ready;
  assign need_seq   = req_reset | (req_clk_sel != ext_clk_sel_q);
  // A kick on the expiry edge suppresses the watchdog reset.
  assign wdt_expire = (state_q == S_IDLE) & wdt_enable & ~wdt_kick & (wdt_cnt_q == WDT_MAX);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sel_d         = sel_q;
    ext_clk_sel_d = ext_clk_sel_q;
    done_d        = 1'b0;
    wdt_fired_d   = wdt_fired_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sel_d = req_clk_sel;
          if (need_seq) begin
            state_d = S_ASSERT;
            cnt_d   = '0;
          end else begin
            done_d = 1'b1;
          end
        end else if (wdt_expire) begin
          sel_d       = ext_clk_sel_q;
          state_d     = S_ASSERT;
          cnt_d       = '0;
          wdt_fired_d = 1'b1;
        end
      end
      S_ASSERT: begin
        if (cnt_q == PRE_LAST) begin
          state_d = S_SWITCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SWITCH: begin
        ext_clk_sel_d = sel_q;
        state_d       = S_SETTLE;
        cnt_d         = '0;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    ext_reset_d = (state_d == S_ASSERT) | (state_d == S_SWITCH) | (state_d == S_SETTLE);
  end

  // Watchdog only advances in IDLE; any expiry edge or sequence start clears it.
  always_comb begin
    wdt_cnt_d = wdt_cnt_q;
    if (wdt_kick | ~wdt_enable) begin
      wdt_cnt_d = '0;
    end else if (state_q == S_IDLE) begin
      if ((wdt_cnt_q == WDT_MAX) || (state_d == S_ASSERT)) begin
        wdt_cnt_d = '0;
      end else begin
        wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      sel_q         <= 1'b0;
      ext_reset_q   <= 1'b0;
      ext_clk_sel_q <= 1'b0;
      done_q        <= 1'b0;
      wdt_cnt_q     <= '0;
      wdt_fired_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      ext_reset_q   <= ext_reset_d;
      ext_clk_sel_q <= ext_clk_sel_d;
      done_q        <= done_d;
      wdt_cnt_q     <= wdt_cnt_d;
      wdt_fired_q   <= wdt_fired_d;
    end
  end

endmodule
